// File: rtl/rv_pkg.sv
// Shared definitions for the RISC-V core: sequencer states, reset PC,
// the sequential PC step and the ALU control codes also used by decode.
package rv_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } seq_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    localparam logic [3:0] ALU_ADD    = 4'h0;
    localparam logic [3:0] ALU_SUB    = 4'h1;
    localparam logic [3:0] ALU_SLL    = 4'h2;
    localparam logic [3:0] ALU_SLT    = 4'h3;
    localparam logic [3:0] ALU_SLTU   = 4'h4;
    localparam logic [3:0] ALU_XOR    = 4'h5;
    localparam logic [3:0] ALU_SRL    = 4'h6;
    localparam logic [3:0] ALU_SRA    = 4'h7;
    localparam logic [3:0] ALU_OR     = 4'h8;
    localparam logic [3:0] ALU_AND    = 4'h9;
    localparam logic [3:0] ALU_PASS_B = 4'hA;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection (jalr > jal > taken branch > pc+4)
// together with the misaligned-target check.
module next_pc_calc
    import rv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        branch_condition,
    output logic [31:0] target,
    output logic        misaligned
);

    always_comb begin
        target = pc + PC_STEP;
        if (is_jalr) begin
            target = alu_result & ~32'h0000_0001;
        end else if (is_jal || (is_branch && branch_condition)) begin
            target = pc + imm;
        end
    end

    assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer: fetches over a req/rvalid handshake,
// holds the instruction until commit, then advances the PC or traps.
module pc_sequencer
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        commit,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        branch_condition,
    output logic        trap,
    output logic [31:0] trap_pc,
    output logic [63:0] instret
);

    seq_state_t  state, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] instr_q, instr_n;
    logic [63:0] instret_q, instret_n;
    logic        trap_q, trap_n;
    logic [31:0] trap_pc_q, trap_pc_n;
    logic [31:0] target;
    logic        misaligned;

    next_pc_calc u_next_pc_calc (
        .pc               (pc_q),
        .imm              (imm),
        .alu_result       (alu_result),
        .is_branch        (is_branch),
        .is_jal           (is_jal),
        .is_jalr          (is_jalr),
        .branch_condition (branch_condition),
        .target           (target),
        .misaligned       (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            instret_q <= 64'h0;
            trap_q    <= 1'b0;
            trap_pc_q <= 32'h0;
        end else begin
            state     <= state_n;
            pc_q      <= pc_n;
            instr_q   <= instr_n;
            instret_q <= instret_n;
            trap_q    <= trap_n;
            trap_pc_q <= trap_pc_n;
        end
    end

    // Everything holds by default, which covers EXEC stalls and HALT.
    always_comb begin
        state_n   = state;
        pc_n      = pc_q;
        instr_n   = instr_q;
        instret_n = instret_q;
        trap_n    = trap_q;
        trap_pc_n = trap_pc_q;
        unique case (state)
            FETCH: begin
                if (imem_rvalid) begin
                    instr_n = imem_rdata;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (commit) begin
                    if (misaligned) begin
                        trap_n    = 1'b1;
                        trap_pc_n = target;
                        state_n   = HALT;
                    end else begin
                        pc_n      = target;
                        instret_n = instret_q + 64'd1;
                        state_n   = FETCH;
                    end
                end
            end
            HALT: begin
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state == EXEC);
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + PC_STEP;
    assign trap        = trap_q;
    assign trap_pc     = trap_pc_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer, checked against an
// instruction-level model of PC, retire count and trap behaviour.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit = 1'b0;
    logic        is_branch = 1'b0;
    logic        is_jal = 1'b0;
    logic        is_jalr = 1'b0;
    logic [31:0] imm = 32'h0;
    logic [31:0] alu_result = 32'h0;
    logic        branch_condition = 1'b0;
    logic        trap;
    logic [31:0] trap_pc;
    logic [63:0] instret;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [63:0] exp_instret;
    logic        exp_trap;
    logic [31:0] exp_trap_pc;

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .commit           (commit),
        .is_branch        (is_branch),
        .is_jal           (is_jal),
        .is_jalr          (is_jalr),
        .imm              (imm),
        .alu_result       (alu_result),
        .branch_condition (branch_condition),
        .trap             (trap),
        .trap_pc          (trap_pc),
        .instret          (instret)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_arch_state(input string tag);
        logic [31:0] p4;
        p4 = exp_pc + 32'd4;
        check_output({tag, "_pc"}, {32'h0, pc}, {32'h0, exp_pc});
        check_output({tag, "_addr"}, {32'h0, imem_addr}, {32'h0, exp_pc});
        check_output({tag, "_pc4"}, {32'h0, pc_plus4}, {32'h0, p4});
        check_output({tag, "_instr"}, {32'h0, instr}, {32'h0, exp_instr});
        check_output({tag, "_instret"}, instret, exp_instret);
        check_output({tag, "_trap"}, {63'h0, trap}, {63'h0, exp_trap});
        check_output({tag, "_trap_pc"}, {32'h0, trap_pc}, {32'h0, exp_trap_pc});
    endtask

    // Resets the DUT and the model; checks asynchronous clear and the first FETCH cycle.
    task automatic do_reset();
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        commit      = 1'b0;
        #2;
        exp_pc      = 32'h0;
        exp_instr   = 32'h0;
        exp_instret = 64'h0;
        exp_trap    = 1'b0;
        exp_trap_pc = 32'h0;
        check_arch_state("rst_async");
        check_output("rst_async_valid", {63'h0, instr_valid}, 64'h0);
        step();
        rst_n = 1'b1;
        check_arch_state("rst_rel");
        check_output("rst_rel_req", {63'h0, imem_req}, 64'h1);
        check_output("rst_rel_valid", {63'h0, instr_valid}, 64'h0);
    endtask

    // One full instruction: fetch with given latency, stall, then commit with the given flags.
    task automatic apply_stimulus(input logic [31:0] rdata, input int lat, input int stall,
                                  input logic br, input logic jal, input logic jalr,
                                  input logic cond, input logic [31:0] imm_v,
                                  input logic [31:0] alu_v);
        logic [31:0] tgt;
        logic [31:0] p4;
        check_output("fetch_req", {63'h0, imem_req}, 64'h1);
        check_output("fetch_addr", {32'h0, imem_addr}, {32'h0, exp_pc});
        for (int i = 0; i < lat - 1; i++) begin
            imem_rvalid = 1'b0;
            commit      = 1'($urandom);
            step();
            check_output("req_held", {63'h0, imem_req}, 64'h1);
            check_output("wait_valid", {63'h0, instr_valid}, 64'h0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = rdata;
        commit      = 1'($urandom);
        step();
        exp_instr   = rdata;
        imem_rvalid = 1'b0;
        commit      = 1'b0;
        p4 = exp_pc + 32'd4;
        check_output("exec_valid", {63'h0, instr_valid}, 64'h1);
        check_output("exec_req", {63'h0, imem_req}, 64'h0);
        check_output("exec_pc4", {32'h0, pc_plus4}, {32'h0, p4});
        check_arch_state("exec");
        for (int i = 0; i < stall; i++) begin
            commit      = 1'b0;
            is_branch   = 1'($urandom);
            is_jal      = 1'($urandom);
            is_jalr     = 1'($urandom);
            imem_rvalid = 1'($urandom);
            imem_rdata  = $urandom;
            step();
            check_output("stall_valid", {63'h0, instr_valid}, 64'h1);
            check_arch_state("stall");
        end
        imem_rvalid      = 1'b0;
        is_branch        = br;
        is_jal           = jal;
        is_jalr          = jalr;
        branch_condition = cond;
        imm              = imm_v;
        alu_result       = alu_v;
        commit           = 1'b1;
        step();
        commit    = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        if (jalr)                   tgt = alu_v - (alu_v % 2);
        else if (jal || (br && cond)) tgt = exp_pc + imm_v;
        else                        tgt = exp_pc + 32'd4;
        if (tgt % 4 != 0) begin
            exp_trap    = 1'b1;
            exp_trap_pc = tgt;
        end else begin
            exp_pc      = tgt;
            exp_instret = exp_instret + 64'd1;
        end
        check_arch_state("post");
        check_output("post_req", {63'h0, imem_req}, {63'h0, !exp_trap});
        check_output("post_valid", {63'h0, instr_valid}, 64'h0);
        if (exp_trap) begin
            for (int i = 0; i < 2; i++) begin
                imem_rvalid = 1'b1;
                imem_rdata  = $urandom;
                commit      = 1'b1;
                step();
                check_output("halt_req", {63'h0, imem_req}, 64'h0);
                check_output("halt_valid", {63'h0, instr_valid}, 64'h0);
                check_arch_state("halt");
            end
            imem_rvalid = 1'b0;
            commit      = 1'b0;
        end
    endtask

    task automatic goto_pc(input logic [31:0] dest);
        apply_stimulus(32'h0000_006f, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0, dest - exp_pc, 32'h0);
    endtask

    initial begin
        logic [31:0] r_imm;
        logic [31:0] r_alu;
        $display("[TB] start");
        do_reset();

        apply_stimulus(32'h0000_0013, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_output("nop_addr4", {32'h0, imem_addr}, 64'h4);
        check_output("nop_instret1", instret, 64'h1);

        goto_pc(32'h10);
        apply_stimulus(32'h0000_0063, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0);
        check_output("br_taken", {32'h0, pc}, 64'h08);
        goto_pc(32'h10);
        apply_stimulus(32'h0000_0063, 2, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
        check_output("br_not_taken", {32'h0, pc}, 64'h14);

        goto_pc(32'h20);
        apply_stimulus(32'h0000_0067, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h101);
        check_output("jalr_pc", {32'h0, pc}, 64'h100);
        check_output("jalr_notrap", {63'h0, trap}, 64'h0);

        apply_stimulus(32'hDEAD_BEEF, 3, 5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        goto_pc(32'h40);
        apply_stimulus(32'h0060_006f, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h6, 32'h0);
        check_output("jal_trap", {63'h0, trap}, 64'h1);
        check_output("jal_trap_pc", {32'h0, trap_pc}, 64'h46);
        check_output("jal_pc_hold", {32'h0, pc}, 64'h40);
        do_reset();

        for (int i = 0; i < 3; i++)
            apply_stimulus(32'h0000_0013, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        step();
        imem_rvalid = 1'b0;
        check_output("pre_rst_valid", {63'h0, instr_valid}, 64'h1);
        check_output("pre_rst_instret", instret, 64'h3);
        do_reset();

        goto_pc(32'hFFFF_FFFC);
        apply_stimulus(32'h0000_0013, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_output("wrap_pc", {32'h0, pc}, 64'h0);
        check_output("wrap_notrap", {63'h0, trap}, 64'h0);

        for (int n = 0; n < 40; n++) begin
            r_imm = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) r_imm = r_imm | 32'h2;
            r_alu = $urandom & 32'hFFFF_FFFD;
            if ($urandom_range(0, 7) == 0) r_alu = r_alu | 32'h2;
            apply_stimulus($urandom, $urandom_range(1, 4), $urandom_range(0, 3),
                           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                           r_imm, r_alu);
            if (exp_trap) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
